// File: rtl/ex_mem_dmem_pkg.sv
// ex_mem_dmem_pkg
// Shared definitions for the EX/MEM stage with its multi-cycle data memory port:
// WB control bit positions, FSM state encoding, the stage-register record,
// the bubble constant, and a helper that flags misaligned memory operations.
package ex_mem_dmem_pkg;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0]  wb;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  mux;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '0;

  // A load or store whose byte address is not word aligned.
  function automatic logic is_misaligned(stage_t s);
    return (s.mr | s.mw) && (s.alu[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/ex_mem_dmem_dmem.sv
// dmem
// Word-addressed data memory: DEPTH x 32 bits, synchronous write, asynchronous
// read, contents not reset.
// Ports:
//   clk   - write clock
//   we    - write enable
//   addr  - word address (shared by read and write)
//   wdata - write data
//   rdata - combinational read data at addr
module dmem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Storage has no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ex_mem_dmem.sv
// ex_mem_dmem
// EX/MEM pipeline register fused with a multi-cycle data memory port. The EX
// result is latched and held while a load/store waits LATENCY cycles; upstream
// stages are stalled meanwhile and MEM/WB only ever sees one non-bubble record
// per instruction.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   pi2_wb        - WB controls from EX ([0] RegWrite, [1] MemtoReg)
//   pi2_MemRead   - load
//   pi2_MemWrite  - store
//   pi2_ALU       - byte address / ALU result
//   pi2_WD        - store data
//   pi2_MUX       - destination register number
//   flush         - load a bubble instead of the EX values (ignored while stalled)
//   pi3_wb        - WB controls to MEM/WB, 2'b00 while waiting
//   pi4_RD        - load data (0 unless a load is completing)
//   pi3_ADDR      - latched ALU result
//   pi3_MUX       - latched destination register
//   stall         - freeze PC, IF/ID, ID/EX and EX
//   misalign      - sticky flag: a misaligned load/store was seen
module ex_mem_dmem
  import ex_mem_dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pi2_wb,
  input  logic        pi2_MemRead,
  input  logic        pi2_MemWrite,
  input  logic [31:0] pi2_ALU,
  input  logic [31:0] pi2_WD,
  input  logic [4:0]  pi2_MUX,
  input  logic        flush,
  output logic [1:0]  pi3_wb,
  output logic [31:0] pi4_RD,
  output logic [31:0] pi3_ADDR,
  output logic [4:0]  pi3_MUX,
  output logic        stall,
  output logic        misalign
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  stage_t            s_q, s_d, ex_rec;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              misalign_q, misalign_d;
  logic              complete;
  logic              bad_op;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  // State register: stage record, FSM state, wait counter and the sticky flag.
  // Reset drops any pending store and releases stall immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q        <= STAGE_BUBBLE;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      s_q        <= s_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state logic. In WAIT the record is frozen and the counter runs down;
  // leaving WAIT when it steps from 1 to 0 gives LATENCY stall cycles. In IDLE
  // the current record is completing, so the next one (or a bubble) is loaded.
  always_comb begin
    ex_rec     = '{wb: pi2_wb, mr: pi2_MemRead, mw: pi2_MemWrite,
                   alu: pi2_ALU, wd: pi2_WD, mux: pi2_MUX};
    s_d        = s_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    if (state_q == ST_WAIT) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
      end
    end else begin
      s_d = flush ? STAGE_BUBBLE : ex_rec;
      if ((s_d.mr | s_d.mw) && (LATENCY > 0)) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_W'(LATENCY);
      end else begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
      if (is_misaligned(s_d)) begin
        misalign_d = 1'b1;
      end
    end
  end

  // Output logic. A record completes in its first non-stalled cycle; a
  // misaligned op still completes but neither writes memory nor the register
  // file. A store with MemRead also set behaves as a pure store.
  always_comb begin
    stall    = (state_q == ST_WAIT);
    complete = ~stall;
    bad_op   = is_misaligned(s_q);
    mem_we   = complete & s_q.mw & ~bad_op;
    pi3_wb   = 2'b00;
    if (complete) begin
      pi3_wb = s_q.wb;
      if (bad_op) begin
        pi3_wb[WB_REGWRITE] = 1'b0;
      end
    end
    pi4_RD   = (complete & s_q.mr & ~s_q.mw) ? mem_rdata : 32'h0;
  end

  assign pi3_ADDR = s_q.alu;
  assign pi3_MUX  = s_q.mux;
  assign misalign = misalign_q;

  dmem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (s_q.alu[ADDR_W+1:2]),
    .wdata (s_q.wd),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_ex_mem_dmem.sv
// tb_ex_mem_dmem
// Directed self-checking bench for ex_mem_dmem with DEPTH=64, LATENCY=2.
module tb_ex_mem_dmem;

  logic        clk;
  logic        rst;
  logic [1:0]  pi2_wb;
  logic        pi2_MemRead;
  logic        pi2_MemWrite;
  logic [31:0] pi2_ALU;
  logic [31:0] pi2_WD;
  logic [4:0]  pi2_MUX;
  logic        flush;
  logic [1:0]  pi3_wb;
  logic [31:0] pi4_RD;
  logic [31:0] pi3_ADDR;
  logic [4:0]  pi3_MUX;
  logic        stall;
  logic        misalign;

  int checks;
  int failures;

  ex_mem_dmem #(
    .DEPTH   (64),
    .LATENCY (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pi2_wb       (pi2_wb),
    .pi2_MemRead  (pi2_MemRead),
    .pi2_MemWrite (pi2_MemWrite),
    .pi2_ALU      (pi2_ALU),
    .pi2_WD       (pi2_WD),
    .pi2_MUX      (pi2_MUX),
    .flush        (flush),
    .pi3_wb       (pi3_wb),
    .pi4_RD       (pi4_RD),
    .pi3_ADDR     (pi3_ADDR),
    .pi3_MUX      (pi3_MUX),
    .stall        (stall),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one EX-stage record onto the inputs.
  task automatic applyStimulus(input logic [1:0] wb, input logic mr, input logic mw,
                               input logic [31:0] alu, input logic [31:0] wd,
                               input logic [4:0] mux, input logic fl);
    pi2_wb       = wb;
    pi2_MemRead  = mr;
    pi2_MemWrite = mw;
    pi2_ALU      = alu;
    pi2_WD       = wd;
    pi2_MUX      = mux;
    flush        = fl;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    rst = 1'b0;
    checkOutput("reset_stall", 32'(stall), 32'h0);
    checkOutput("reset_wb", 32'(pi3_wb), 32'h0);
    checkOutput("reset_rd", pi4_RD, 32'h0);
    checkOutput("reset_addr", pi3_ADDR, 32'h0);
    checkOutput("reset_mux", 32'(pi3_MUX), 32'h0);
    checkOutput("reset_misalign", 32'(misalign), 32'h0);

    // Plain ALU op passes through in one cycle
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd8, 1'b0);
    step();
    checkOutput("alu_wb", 32'(pi3_wb), 32'h1);
    checkOutput("alu_addr", pi3_ADDR, 32'h1234);
    checkOutput("alu_mux", 32'(pi3_MUX), 32'h8);
    checkOutput("alu_stall", 32'(stall), 32'h0);
    checkOutput("alu_rd", pi4_RD, 32'h0);

    // Reset asserted mid-cycle clears outputs without a clock edge
    rst = 1'b1;
    #1;
    checkOutput("async_rst_addr", pi3_ADDR, 32'h0);
    checkOutput("async_rst_mux", 32'(pi3_MUX), 32'h0);
    checkOutput("async_rst_wb", 32'(pi3_wb), 32'h0);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("post_rst_stall", 32'(stall), 32'h0);

    // sw 0xDEADBEEF -> 0x10, followed immediately by lw 0x10
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    step();
    checkOutput("sw_stall1", 32'(stall), 32'h1);
    checkOutput("sw_wb1", 32'(pi3_wb), 32'h0);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd9, 1'b0);
    step();
    checkOutput("sw_stall2", 32'(stall), 32'h1);
    step();
    checkOutput("sw_done_stall", 32'(stall), 32'h0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    checkOutput("lw_stall1", 32'(stall), 32'h1);
    checkOutput("lw_wb_wait1", 32'(pi3_wb), 32'h0);
    checkOutput("lw_rd_wait1", pi4_RD, 32'h0);
    step();
    checkOutput("lw_stall2", 32'(stall), 32'h1);
    checkOutput("lw_wb_wait2", 32'(pi3_wb), 32'h0);
    step();
    checkOutput("lw_done_stall", 32'(stall), 32'h0);
    checkOutput("lw_rd", pi4_RD, 32'hDEADBEEF);
    checkOutput("lw_wb", 32'(pi3_wb), 32'h3);
    checkOutput("lw_mux", 32'(pi3_MUX), 32'h9);

    // Flush while not stalled turns a store into a bubble
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h10, 32'h12345678, 5'd0, 1'b1);
    step();
    checkOutput("flush_stall", 32'(stall), 32'h0);
    checkOutput("flush_wb", 32'(pi3_wb), 32'h0);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd3, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    checkOutput("flush_nowrite_rd", pi4_RD, 32'hDEADBEEF);

    // Flush while stalled is ignored; it applies once stall drops
    applyStimulus(2'b01, 1'b1, 1'b0, 32'h10, 32'h0, 5'd4, 1'b0);
    step();
    checkOutput("flush_wait_stall", 32'(stall), 32'h1);
    applyStimulus(2'b01, 1'b0, 1'b0, 32'h99, 32'h0, 5'd7, 1'b1);
    step();
    step();
    checkOutput("flush_ign_wb", 32'(pi3_wb), 32'h1);
    checkOutput("flush_ign_mux", 32'(pi3_MUX), 32'h4);
    checkOutput("flush_ign_rd", pi4_RD, 32'hDEADBEEF);
    step();
    checkOutput("flush_late_wb", 32'(pi3_wb), 32'h0);
    checkOutput("flush_late_mux", 32'(pi3_MUX), 32'h0);
    checkOutput("pre_mis_flag", 32'(misalign), 32'h0);

    // Misaligned store: full latency, no write, sticky flag
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h13, 32'h11111111, 5'd0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    checkOutput("mis_sw_stall2", 32'(stall), 32'h1);
    step();
    checkOutput("mis_sw_done", 32'(stall), 32'h0);
    checkOutput("mis_flag", 32'(misalign), 32'h1);
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    checkOutput("mis_nowrite_rd", pi4_RD, 32'hDEADBEEF);
    checkOutput("mis_flag_sticky", 32'(misalign), 32'h1);

    // Misaligned load: RegWrite suppressed at completion
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h13, 32'h0, 5'd6, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    checkOutput("mis_lw_wb", 32'(pi3_wb), 32'h2);
    checkOutput("mis_lw_mux", 32'(pi3_MUX), 32'h6);

    // Upper address bits are ignored: 0x110 aliases word 4
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h110, 32'h0, 5'd2, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    checkOutput("wrap_rd", pi4_RD, 32'hDEADBEEF);
    checkOutput("wrap_addr", pi3_ADDR, 32'h110);

    // Seed mem[8], then reset during the first stall of a store to it
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 5'd0, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    applyStimulus(2'b00, 1'b0, 1'b1, 32'h20, 32'h55, 5'd0, 1'b0);
    step();
    checkOutput("rstwait_stall_pre", 32'(stall), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstwait_stall", 32'(stall), 32'h0);
    checkOutput("rstwait_addr", pi3_ADDR, 32'h0);
    checkOutput("rstwait_wb", 32'(pi3_wb), 32'h0);
    checkOutput("rstwait_misalign", 32'(misalign), 32'h0);
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    rst = 1'b0;
    applyStimulus(2'b11, 1'b1, 1'b0, 32'h20, 32'h0, 5'd1, 1'b0);
    step();
    applyStimulus(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    step();
    checkOutput("rstwait_mem_kept", pi4_RD, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
